// File: rtl/dec_to_bin_if.sv
// ============================================================================
// Module : dec_to_bin_if
// Brief  : Request/result bundle for the BCD-to-binary converter.
//          master : requester (drives start, bcd_digits; observes results)
//          slave  : converter (samples start, bcd_digits; drives results)
// Ports  : start       - level request
//          bcd_digits  - DIGITS x 4-bit BCD digits, index 0 = least significant
//          bin_data    - binary result, WIDTH bits
//          done/busy   - status decoded from the converter state
//          invalid     - captured input contained a digit > 9
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dec_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic             start;
  logic [3:0]       bcd_digits [DIGITS];
  logic [WIDTH-1:0] bin_data;
  logic             done;
  logic             busy;
  logic             invalid;

  modport master (
    output start, bcd_digits,
    input  bin_data, done, busy, invalid
  );

  modport slave (
    input  start, bcd_digits,
    output bin_data, done, busy, invalid
  );
endinterface

`default_nettype wire

// File: rtl/dec_to_bin.sv
// ============================================================================
// Module : dec_to_bin
// Brief  : Sequential BCD-to-binary converter (reverse double-dabble).
//          One right shift of {bcd_sr, bin_sr} per cycle, then every BCD
//          digit >= 8 is reduced by 3. Result after 4*DIGITS iterations.
// Ports  : clk_i    - clock, rising edge
//          reset_ni - asynchronous active-low reset
//          bus      - dec_to_bin_if.slave (start, bcd_digits, bin_data,
//                     done, busy, invalid)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_to_bin #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  wire         clk_i,
  input  wire         reset_ni,
  dec_to_bin_if.slave bus
);

  localparam int NBITS = 4 * DIGITS;
  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] bcd_sr_q, bcd_sr_d;
  logic [NBITS-1:0] bin_sr_q, bin_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_pend_q, inv_pend_d;
  logic [WIDTH-1:0] bin_data_q, bin_data_d;
  logic             invalid_q, invalid_d;

  logic [2*NBITS-1:0] w_shift;
  logic [NBITS-1:0]   w_bcd_adj;
  logic               w_any_invalid;
  logic               w_busy, w_done;

  // Shift the concatenated pair right; the bcd LSB falls into the bin MSB.
  assign w_shift = {1'b0, bcd_sr_q, bin_sr_q[NBITS-1:1]};

  // Digit correction applies to the BCD half only.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [3:0] w_dig;
      assign w_dig = w_shift[NBITS + 4*i +: 4];
      assign w_bcd_adj[4*i +: 4] = (w_dig >= 4'd8) ? (w_dig - 4'd3) : w_dig;
    end
  endgenerate

  always_comb begin
    w_any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_digits[i] > 4'd9) w_any_invalid = 1'b1;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = bus.start ? S_RUNNING : S_IDLE;
      S_RUNNING: state_d = (cnt_q == CNT_LAST) ? S_DONE : S_RUNNING;
      S_DONE:    state_d = bus.start ? S_DONE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (state decode only) ----------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (state_q)
      S_RUNNING: w_busy = 1'b1;
      S_DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    bcd_sr_d   = bcd_sr_q;
    bin_sr_d   = bin_sr_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q;
    bin_data_d = bin_data_q;
    invalid_d  = invalid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < DIGITS; i++) bcd_sr_d[4*i +: 4] = bus.bcd_digits[i];
          bin_sr_d   = '0;
          cnt_d      = '0;
          inv_pend_d = w_any_invalid;
        end
      end
      S_RUNNING: begin
        bcd_sr_d = w_bcd_adj;
        bin_sr_d = w_shift[NBITS-1:0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Upper NBITS-WIDTH bits are zero for legal input.
          bin_data_d = inv_pend_q ? '0 : w_shift[WIDTH-1:0];
          invalid_d  = inv_pend_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bcd_sr_q   <= '0;
      bin_sr_q   <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      bin_data_q <= '0;
      invalid_q  <= 1'b0;
    end else begin
      bcd_sr_q   <= bcd_sr_d;
      bin_sr_q   <= bin_sr_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
      bin_data_q <= bin_data_d;
      invalid_q  <= invalid_d;
    end
  end

  assign bus.bin_data = bin_data_q;
  assign bus.invalid  = invalid_q;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;

endmodule

`default_nettype wire

// File: tb/tb_dec_to_bin.sv
// ============================================================================
// Module : tb_dec_to_bin
// Brief  : Scoreboard bench for dec_to_bin. Stimulus pushes the hand-computed
//          result and expected done cycle; a monitor pops on each done rise.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_to_bin;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;
  localparam int LAT    = 4 * DIGITS;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic             inv;
    int               cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  dec_to_bin_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  dec_to_bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) u_dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- Monitor ----------------
  initial begin : monitor
    logic done_prev;
    int   busy_cnt;
    exp_t e;
    done_prev = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        done_prev = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1 && !done_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("bin_data", int'(bus.bin_data), int'(e.bin));
            check("invalid", int'(bus.invalid), int'(e.inv));
            check("latency_cycle", cyc, e.cyc);
            check("busy_cycles", busy_cnt, LAT);
          end
          busy_cnt = 0;
        end
        done_prev = bus.done;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic issue(input int d3, input int d2, input int d1, input int d0,
                       input int exp_bin, input bit exp_inv);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk_i);
    while ((bus.busy || bus.done) && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) check("idle_timeout", 0, 1);
    bus.bcd_digits[3] = 4'(d3);
    bus.bcd_digits[2] = 4'(d2);
    bus.bcd_digits[1] = 4'(d1);
    bus.bcd_digits[0] = 4'(d0);
    bus.start = 1'b1;
    @(posedge clk_i);
    #1;
    e.bin = WIDTH'(exp_bin);
    e.inv = exp_inv;
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  // Waits for done with start still held, then optionally drops start.
  task automatic wait_done(input bit drop);
    int n;
    n = 0;
    @(negedge clk_i);
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 40) check("done_timeout", 0, 1);
    if (drop) bus.start = 1'b0;
  endtask

  // ---------------- Stimulus ----------------
  initial begin : stim
    bus.start = 1'b0;
    for (int i = 0; i < DIGITS; i++) bus.bcd_digits[i] = 4'd0;

    repeat (3) @(negedge clk_i);
    check("rst_bin_data", int'(bus.bin_data), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_invalid", int'(bus.invalid), 0);
    reset_ni = 1'b1;

    // 1. 1234, start held through the conversion
    issue(1, 2, 3, 4, 16'h04D2, 1'b0);
    wait_done(1'b1);

    // 2. extremes
    issue(9, 9, 9, 9, 16'h270F, 1'b0);
    wait_done(1'b1);
    issue(0, 0, 0, 0, 0, 1'b0);
    wait_done(1'b1);

    // 3. invalid digit forces 0, then a valid request clears invalid
    issue(1, 10, 0, 5, 0, 1'b1);
    wait_done(1'b1);
    issue(0, 0, 4, 2, 42, 1'b0);
    wait_done(1'b0);

    // 4. start held past DONE: no re-conversion
    repeat (5) begin
      @(negedge clk_i);
      check("hold_done", int'(bus.done), 1);
      check("hold_busy", int'(bus.busy), 0);
      check("hold_bin", int'(bus.bin_data), 42);
    end
    bus.start = 1'b0;
    issue(8, 0, 0, 8, 16'h1F48, 1'b0);
    wait_done(1'b1);

    // 5. input churn while RUNNING is ignored
    issue(5, 6, 7, 8, 5678, 1'b0);
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < DIGITS; i++) bus.bcd_digits[i] = 4'd9;
    bus.start = 1'b0;
    @(negedge clk_i);
    bus.start = 1'b1;
    bus.bcd_digits[0] = 4'd1;
    @(negedge clk_i);
    bus.start = 1'b0;
    wait_done(1'b1);

    // 6. reset during iteration 7 aborts; no result is produced
    issue(9, 8, 7, 6, 9876, 1'b0);
    bus.start = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    reset_ni = 1'b0;
    void'(sb.pop_back());
    #1;
    check("abort_bin_data", int'(bus.bin_data), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_invalid", int'(bus.invalid), 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    issue(0, 0, 1, 0, 10, 1'b0);
    wait_done(1'b1);

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
